// File: rtl/sm4_key_sched_if.sv
// ============================================================================
// Module      : sm4_key_sched_if
// Description : Key-load and round-key read bundle between the key loader /
//               cipher datapath (master) and the SM4 key-expansion engine
//               (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sm4_key_sched_if;
  logic [127:0] MK_i;
  logic         MK_VALID_i;
  logic         MK_READY_o;
  logic         KEY_READY_o;
  logic [4:0]   RK_ADDR_i;
  logic         DEC_i;
  logic [31:0]  RK_o;
  logic         BUSY_o;

  modport master (
    output MK_i, MK_VALID_i, RK_ADDR_i, DEC_i,
    input  MK_READY_o, KEY_READY_o, RK_o, BUSY_o
  );

  modport slave (
    input  MK_i, MK_VALID_i, RK_ADDR_i, DEC_i,
    output MK_READY_o, KEY_READY_o, RK_o, BUSY_o
  );
endinterface

`default_nettype wire

// File: rtl/sm4_key_sched.sv
// ============================================================================
// Module      : sm4_key_sched
// Description : Iterative SM4 key expansion, RPC rounds per clock. Builds a
//               32-entry round-key table read in encrypt or decrypt order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sm4_key_sched #(
  parameter int RPC    = 1,
  parameter int RD_REG = 1
) (
  input  wire logic        CLK_i,
  input  wire logic        RST_i,
  sm4_key_sched_if.slave   bus
);

  // Reject round counts that do not tile the 32 rounds evenly.
  generate
    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
      $error("sm4_key_sched: RPC must be 1, 2, 4 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] c_fk [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

  localparam logic [7:0] c_sbox [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // CK word for round i: byte j (j=0 is MSB) is (4*i+j)*7 with 8-bit wrap.
  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [31:0] w;
    logic [7:0]  b;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      b = 8'({i, 2'(j)});
      w[31-8*j -: 8] = b * 8'd7;
    end
    return w;
  endfunction

  // Key-schedule T': byte-wise S-box followed by L'(y) = y ^ y<<<13 ^ y<<<23.
  function automatic logic [31:0] t_prime(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int b = 0; b < 4; b++) begin
      y[8*b +: 8] = c_sbox[x[8*b +: 8]];
    end
    return y ^ {y[18:0], y[31:19]} ^ {y[8:0], y[31:9]};
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        key_ready_q, key_ready_d;
  logic [31:0] kwin_q [4];
  logic [31:0] kwin_d [4];
  logic [31:0] rk_tbl_q [32];
  logic [31:0] rk_tbl_d [32];

  logic [31:0] w_win [4];
  logic [31:0] w_new;
  logic [4:0]  w_round;
  logic [4:0]  w_rd_idx;

  // Next-state logic: key accept, RPC chained rounds per cycle, table writes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_ready_d = key_ready_q;
    kwin_d      = kwin_q;
    rk_tbl_d    = rk_tbl_q;
    w_win       = kwin_q;
    w_new       = '0;
    w_round     = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.MK_VALID_i) begin
          state_d     = ST_EXPAND;
          cnt_d       = '0;
          key_ready_d = 1'b0;
          for (int j = 0; j < 4; j++) begin
            kwin_d[j] = bus.MK_i[127-32*j -: 32] ^ c_fk[j];
          end
        end
      end
      ST_EXPAND: begin
        for (int r = 0; r < RPC; r++) begin
          w_round           = cnt_q + 5'(r);
          w_new             = w_win[0] ^ t_prime(w_win[1] ^ w_win[2] ^ w_win[3] ^ ck_word(w_round));
          rk_tbl_d[w_round] = w_new;
          w_win[0]          = w_win[1];
          w_win[1]          = w_win[2];
          w_win[2]          = w_win[3];
          w_win[3]          = w_new;
        end
        kwin_d = w_win;
        cnt_d  = cnt_q + 5'(RPC);
        // Last batch: table complete, counter returns to 0 for the next key.
        if (cnt_q == 5'(32 - RPC)) begin
          state_d     = ST_DONE;
          key_ready_d = 1'b1;
          cnt_d       = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, key window and table registers; reset wipes every stored key.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_ready_q <= 1'b0;
      for (int j = 0; j < 4; j++) kwin_q[j] <= '0;
      for (int e = 0; e < 32; e++) rk_tbl_q[e] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_ready_q <= key_ready_d;
      kwin_q      <= kwin_d;
      rk_tbl_q    <= rk_tbl_d;
    end
  end

  assign w_rd_idx        = bus.DEC_i ? (5'd31 - bus.RK_ADDR_i) : bus.RK_ADDR_i;
  assign bus.MK_READY_o  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign bus.BUSY_o      = (state_q == ST_EXPAND);
  assign bus.KEY_READY_o = key_ready_q;

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [31:0] rd_q, rd_d;

      // Capture only from a valid table so a freshly completed table never exposes old data.
      always_comb begin
        rd_d = key_ready_q ? rk_tbl_q[w_rd_idx] : '0;
      end

      // Registered read port.
      always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) rd_q <= '0;
        else       rd_q <= rd_d;
      end

      assign bus.RK_o = key_ready_q ? rd_q : '0;
    end else begin : g_rd_comb
      assign bus.RK_o = key_ready_q ? rk_tbl_q[w_rd_idx] : '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sm4_key_sched.sv
// ============================================================================
// Module      : tb_sm4_key_sched
// Description : Self-checking bench; five engines (RPC 1/2/4/8 registered
//               read, RPC 2 combinational read) share one stimulus stream and
//               are checked against a behavioural SM4 key-schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sm4_key_sched;

  localparam int c_ndut = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] mk = '0;
  logic         mk_valid = 1'b0;
  logic [4:0]   rk_addr = '0;
  logic         dec = 1'b0;

  logic        mk_ready_v  [c_ndut];
  logic        key_ready_v [c_ndut];
  logic        busy_v      [c_ndut];
  logic [31:0] rk_v        [c_ndut];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < c_ndut; g++) begin : g_dut
    sm4_key_sched_if bus ();
    assign bus.MK_i       = mk;
    assign bus.MK_VALID_i = mk_valid;
    assign bus.RK_ADDR_i  = rk_addr;
    assign bus.DEC_i      = dec;
    assign mk_ready_v[g]  = bus.MK_READY_o;
    assign key_ready_v[g] = bus.KEY_READY_o;
    assign busy_v[g]      = bus.BUSY_o;
    assign rk_v[g]        = bus.RK_o;

    sm4_key_sched #(
      .RPC    (g == 4 ? 2 : (1 << g)),
      .RD_REG (g == 4 ? 0 : 1)
    ) u_dut (
      .CLK_i (clk),
      .RST_i (rst),
      .bus   (bus)
    );
  end

  function automatic int rpc_of(input int d);
    return (d == 4) ? 2 : (1 << d);
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] sbox [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  logic [31:0] ref_rk [32];

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tprime(input logic [31:0] x);
    logic [31:0] y;
    y = 0;
    for (int b = 3; b >= 0; b--) y = (y << 8) | 32'(sbox[(x >> (8 * b)) & 32'hFF]);
    return y ^ rotl(y, 13) ^ rotl(y, 23);
  endfunction

  // Full 36-word K sequence, straight from the recurrence.
  function automatic void model_expand(input logic [127:0] key);
    logic [31:0] kk [36];
    logic [31:0] fk [4];
    logic [31:0] ck;
    fk[0] = 32'hA3B1BAC6; fk[1] = 32'h56AA3350; fk[2] = 32'h677D9197; fk[3] = 32'hB27022DC;
    for (int i = 0; i < 4; i++) kk[i] = 32'(key >> (96 - 32 * i)) ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      ck = 0;
      for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4 * i + j) * 7) % 256);
      kk[i + 4] = kk[i] ^ tprime(kk[i + 1] ^ kk[i + 2] ^ kk[i + 3] ^ ck);
      ref_rk[i] = kk[i + 4];
    end
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  // Present a key for one cycle; returns just after the accept edge (at the following negedge).
  task automatic accept_key(input logic [127:0] key);
    @(negedge clk);
    mk       = key;
    mk_valid = 1'b1;
    @(negedge clk);
    mk_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until each engine raises KEY_READY (-1 if never).
  task automatic wait_ready(output int lat [c_ndut]);
    int got;
    for (int d = 0; d < c_ndut; d++) lat[d] = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      got = 0;
      for (int d = 0; d < c_ndut; d++) begin
        if (key_ready_v[d] === 1'b1 && lat[d] < 0) lat[d] = n;
        if (lat[d] >= 0) got++;
      end
      if (got == c_ndut) break;
    end
  endtask

  // Present an address/direction and sample after the next rising edge.
  task automatic read_rk(input int a, input logic dv);
    @(negedge clk);
    rk_addr = 5'(a);
    dec     = dv;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < c_ndut; d++) begin
      n_cmp += 4;
      if (mk_ready_v[d] !== 1'b1)  begin n_err++; $display("FAIL reset_mk_ready dut%0d got %b want 1", d, mk_ready_v[d]); end
      if (key_ready_v[d] !== 1'b0) begin n_err++; $display("FAIL reset_key_ready dut%0d got %b want 0", d, key_ready_v[d]); end
      if (busy_v[d] !== 1'b0)      begin n_err++; $display("FAIL reset_busy dut%0d got %b want 0", d, busy_v[d]); end
      if (rk_v[d] !== 32'h0)       begin n_err++; $display("FAIL reset_rk dut%0d got %h want 0", d, rk_v[d]); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Accept cycle = cycle 0; KEY_READY is visible 32/RPC edges after the accept edge.
  task automatic test_known_answer();
    int lat [c_ndut];
    accept_key(128'h0123456789ABCDEFFEDCBA9876543210);
    wait_ready(lat);
    for (int d = 0; d < c_ndut; d++) begin
      n_cmp++;
      if (lat[d] != 32 / rpc_of(d)) begin n_err++; $display("FAIL kat_latency dut%0d got %0d want %0d", d, lat[d], 32 / rpc_of(d)); end
    end
    read_rk(0, 1'b0);
    for (int d = 0; d < c_ndut; d++) begin
      n_cmp++;
      if (rk_v[d] !== 32'hF12186F9) begin n_err++; $display("FAIL kat_enc_rk0 dut%0d got %h want F12186F9", d, rk_v[d]); end
    end
    read_rk(31, 1'b0);
    for (int d = 0; d < c_ndut; d++) begin
      n_cmp++;
      if (rk_v[d] !== 32'h9124A012) begin n_err++; $display("FAIL kat_enc_rk31 dut%0d got %h want 9124A012", d, rk_v[d]); end
    end
    read_rk(0, 1'b1);
    for (int d = 0; d < c_ndut; d++) begin
      n_cmp++;
      if (rk_v[d] !== 32'h9124A012) begin n_err++; $display("FAIL kat_dec_addr0 dut%0d got %h want 9124A012", d, rk_v[d]); end
    end
    read_rk(31, 1'b1);
    for (int d = 0; d < c_ndut; d++) begin
      n_cmp++;
      if (rk_v[d] !== 32'hF12186F9) begin n_err++; $display("FAIL kat_dec_addr31 dut%0d got %h want F12186F9", d, rk_v[d]); end
    end
  endtask

  task automatic test_random_tables();
    int lat [c_ndut];
    logic [127:0] key;
    logic dv;
    logic [31:0] exp_rk;
    for (int k = 0; k < 3; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      model_expand(key);
      accept_key(key);
      wait_ready(lat);
      for (int d = 0; d < c_ndut; d++) begin
        n_cmp++;
        if (lat[d] != 32 / rpc_of(d)) begin n_err++; $display("FAIL rand_latency key%0d dut%0d got %0d want %0d", k, d, lat[d], 32 / rpc_of(d)); end
      end
      for (int a = 0; a < 32; a++) begin
        dv = 1'($urandom_range(0, 1));
        read_rk(a, dv);
        exp_rk = dv ? ref_rk[31 - a] : ref_rk[a];
        for (int d = 0; d < c_ndut; d++) begin
          n_cmp++;
          if (rk_v[d] !== exp_rk) begin n_err++; $display("FAIL rand_table key%0d dut%0d addr %0d dec %b got %h want %h", k, d, a, dv, rk_v[d], exp_rk); end
        end
      end
    end
  endtask

  task automatic test_ignore_mid_expand();
    int lat [c_ndut];
    logic [127:0] key_a, key_b;
    key_a = {$urandom, $urandom, $urandom, $urandom};
    key_b = ~key_a;
    model_expand(key_a);
    accept_key(key_a);
    @(posedge clk);
    #1;
    for (int d = 0; d < c_ndut; d++) begin
      n_cmp += 2;
      if (mk_ready_v[d] !== 1'b0) begin n_err++; $display("FAIL mid_mk_ready dut%0d got %b want 0", d, mk_ready_v[d]); end
      if (busy_v[d] !== 1'b1)     begin n_err++; $display("FAIL mid_busy dut%0d got %b want 1", d, busy_v[d]); end
    end
    accept_key(key_b);
    wait_ready(lat);
    for (int d = 0; d < c_ndut; d++) begin
      n_cmp++;
      if (lat[d] < 0) begin n_err++; $display("FAIL mid_timeout dut%0d got %0d want >=0", d, lat[d]); end
    end
    for (int a = 0; a < 32; a++) begin
      read_rk(a, 1'b0);
      for (int d = 0; d < c_ndut; d++) begin
        n_cmp++;
        if (rk_v[d] !== ref_rk[a]) begin n_err++; $display("FAIL mid_table dut%0d addr %0d got %h want %h", d, a, rk_v[d], ref_rk[a]); end
      end
    end
  endtask

  task automatic test_reset_mid_expand();
    int lat [c_ndut];
    logic [127:0] key;
    accept_key({$urandom, $urandom, $urandom, $urandom});
    repeat (16) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int d = 0; d < c_ndut; d++) begin
      n_cmp += 4;
      if (mk_ready_v[d] !== 1'b1)  begin n_err++; $display("FAIL abort_mk_ready dut%0d got %b want 1", d, mk_ready_v[d]); end
      if (key_ready_v[d] !== 1'b0) begin n_err++; $display("FAIL abort_key_ready dut%0d got %b want 0", d, key_ready_v[d]); end
      if (busy_v[d] !== 1'b0)      begin n_err++; $display("FAIL abort_busy dut%0d got %b want 0", d, busy_v[d]); end
      if (rk_v[d] !== 32'h0)       begin n_err++; $display("FAIL abort_rk dut%0d got %h want 0", d, rk_v[d]); end
    end
    @(negedge clk);
    rst = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key);
    accept_key(key);
    wait_ready(lat);
    for (int d = 0; d < c_ndut; d++) begin
      n_cmp++;
      if (lat[d] != 32 / rpc_of(d)) begin n_err++; $display("FAIL abort_latency dut%0d got %0d want %0d", d, lat[d], 32 / rpc_of(d)); end
    end
    for (int a = 0; a < 32; a++) begin
      read_rk(a, 1'b1);
      for (int d = 0; d < c_ndut; d++) begin
        n_cmp++;
        if (rk_v[d] !== ref_rk[31 - a]) begin n_err++; $display("FAIL abort_table dut%0d addr %0d got %h want %h", d, a, rk_v[d], ref_rk[31 - a]); end
      end
    end
  endtask

  // Reload from DONE with an all-zero key: outputs must blank until the new table is complete.
  task automatic test_reload_in_done();
    bit done [c_ndut];
    int got;
    @(negedge clk);
    rk_addr = 5'd5;
    dec     = 1'b0;
    model_expand(128'h0);
    accept_key(128'h0);
    for (int d = 0; d < c_ndut; d++) begin
      done[d] = 1'b0;
      n_cmp++;
      if (key_ready_v[d] !== 1'b0) begin n_err++; $display("FAIL reload_drop dut%0d got %b want 0", d, key_ready_v[d]); end
    end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      got = 0;
      for (int d = 0; d < c_ndut; d++) begin
        if (n == 32 / rpc_of(d)) done[d] = 1'b1;
        if (!done[d]) begin
          n_cmp += 2;
          if (key_ready_v[d] !== 1'b0) begin n_err++; $display("FAIL reload_ready dut%0d cyc %0d got %b want 0", d, n, key_ready_v[d]); end
          if (rk_v[d] !== 32'h0)       begin n_err++; $display("FAIL reload_rk_blank dut%0d cyc %0d got %h want 0", d, n, rk_v[d]); end
        end else begin
          got++;
        end
      end
      if (got == c_ndut) break;
    end
    for (int d = 0; d < c_ndut; d++) begin
      n_cmp++;
      if (key_ready_v[d] !== 1'b1) begin n_err++; $display("FAIL reload_final_ready dut%0d got %b want 1", d, key_ready_v[d]); end
    end
    for (int a = 0; a < 32; a++) begin
      read_rk(a, 1'b0);
      for (int d = 0; d < c_ndut; d++) begin
        n_cmp++;
        if (rk_v[d] !== ref_rk[a]) begin n_err++; $display("FAIL reload_table dut%0d addr %0d got %h want %h", d, a, rk_v[d], ref_rk[a]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_answer();
    test_random_tables();
    test_ignore_mid_expand();
    test_reset_mid_expand();
    test_reload_in_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
